// File: rtl/ddr_burst_arbiter_pkg.sv
// ddr_burst_arbiter_pkg
// Shared definitions for the DDR burst arbiter: default widths and depths,
// the state codes exported to the caches, grant identifiers, the data-cache
// command codes and the fixed-priority grant helper.
// No ports (package).
package ddr_burst_arbiter_pkg;

    localparam int DATA_WIDTH_DEF        = 16;
    localparam int ISA_WIDTH_DEF         = 16;
    localparam int DDR_ADDR_WIDTH_DEF    = 28;
    localparam int DATA_CACHE_DEPTH_DEF  = 16;
    localparam int INSTR_CACHE_DEPTH_DEF = 16;
    localparam int BURST_LEN_WIDTH_DEF   = 10;

    // Beat counters start at 2 so that during beat k they read k + 2.
    localparam int BEAT_CNT_LOAD = 2;

    // The numeric codes are visible to the caches. The data cache decodes
    // MEM_WRITE_DATA_STORE (9) to gate its write-back stream, so it must
    // never be renumbered.
    typedef enum logic [3:0] {
        IDLE                 = 4'd0,
        MEM_READ_INSTR       = 4'd2,
        MEM_READ_DATA        = 4'd5,
        MEM_WRITE_DATA_STORE = 4'd9,
        WAIT_RELEASE         = 4'd12
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE    = 2'd0,
        GNT_INSTR   = 2'd1,
        GNT_DATA_RD = 2'd2,
        GNT_DATA_ST = 2'd3
    } grant_e;

    // Data-cache access commands (row-by-row / column-by-column transfers).
    typedef enum logic [1:0] {
        ROWXROW_LOAD  = 2'd0,
        ROWXROW_STORE = 2'd1,
        COLXCOL_LOAD  = 2'd2,
        COLXCOL_STORE = 2'd3
    } dcache_cmd_e;

    // Fixed priority: write-back first so a dirty line is never lost behind
    // a fill, then data fill, then instruction fill.
    function automatic grant_e pick_grant(input logic store_req,
                                          input logic data_rd_req,
                                          input logic instr_rd_req);
        if (store_req)    return GNT_DATA_ST;
        if (data_rd_req)  return GNT_DATA_RD;
        if (instr_rd_req) return GNT_INSTR;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/ddr_burst_arbiter_if.sv
// ddr_burst_arbiter_if
// Burst read/write bus between the arbiter (master) and the DDR burst
// controller (slave).
//   rd_burst_req/len/addr       master -> slave  read burst request
//   rd_burst_data/_valid_ddr    slave  -> master read beat and strobe
//   rd_burst_finish             slave  -> master read complete pulse
//   wr_burst_req/len/addr       master -> slave  write burst request
//   wr_burst_data               master -> slave  write beat
//   wr_burst_data_req_ddr       slave  -> master write beat request
//   wr_burst_finish             slave  -> master write complete pulse
interface ddr_burst_arbiter_if
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int DDR_ADDR_WIDTH  = DDR_ADDR_WIDTH_DEF,
    parameter int BURST_LEN_WIDTH = BURST_LEN_WIDTH_DEF
);
    logic                       rd_burst_req;
    logic [BURST_LEN_WIDTH-1:0] rd_burst_len;
    logic [DDR_ADDR_WIDTH-1:0]  rd_burst_addr;
    logic [DATA_WIDTH-1:0]      rd_burst_data;
    logic                       rd_burst_data_valid_ddr;
    logic                       rd_burst_finish;
    logic                       wr_burst_req;
    logic [BURST_LEN_WIDTH-1:0] wr_burst_len;
    logic [DDR_ADDR_WIDTH-1:0]  wr_burst_addr;
    logic [DATA_WIDTH-1:0]      wr_burst_data;
    logic                       wr_burst_data_req_ddr;
    logic                       wr_burst_finish;

    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  rd_burst_data, rd_burst_data_valid_ddr, rd_burst_finish,
        output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        input  wr_burst_data_req_ddr, wr_burst_finish
    );

    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output rd_burst_data, rd_burst_data_valid_ddr, rd_burst_finish,
        input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        output wr_burst_data_req_ddr, wr_burst_finish
    );

endinterface

// File: rtl/ddr_burst_arbiter_beat_counter.sv
// burst_beat_counter
// Per-cache read beat counter: load a start value, count up on each beat,
// saturate at all-ones, clear back to zero.
//   clk, rst   clock, asynchronous active-low reset
//   load       load BEAT_CNT_LOAD (burst granted)
//   inc        count one beat
//   clr        clear to zero (highest precedence)
//   cnt        current count
module burst_beat_counter
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int WIDTH = BURST_LEN_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = WIDTH'(BEAT_CNT_LOAD);
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
// Arbitrates instruction line fills, data line fills and data line
// write-backs onto one DDR burst controller, one burst at a time.
//   clk, rst                      clock, asynchronous active-low reset
//   INSTR_read_req/_addr          instruction line fill request
//   INSTR_to_cache, rd_cnt_instr  instruction beat and beat index + 2
//   DATA_read_req/_addr           data line fill request
//   DATA_store_req/_write_addr    data line write-back request
//   DATA_to_ddr                   write-back beat (one cycle after beat req)
//   DATA_to_cache, rd_cnt_data    data beat and beat index + 2
//   rd_burst_data_valid           read beat strobe to both caches
//   wr_burst_data_req             write beat request to the data cache
//   state_interface_module        current state code
//   ddr                           burst bus to the DDR controller
//
// state                | meaning
// IDLE (0)             | no burst; grant store > data read > instr read
// MEM_READ_INSTR (2)   | instruction line fill in flight
// MEM_READ_DATA (5)    | data line fill in flight
// MEM_WRITE_DATA_STORE | data line write-back in flight (code 9)
// WAIT_RELEASE (12)    | burst done; hold counters until requester drops
module ddr_burst_arbiter
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int ISA_WIDTH         = ISA_WIDTH_DEF,
    parameter int DDR_ADDR_WIDTH    = DDR_ADDR_WIDTH_DEF,
    parameter int DATA_CACHE_DEPTH  = DATA_CACHE_DEPTH_DEF,
    parameter int INSTR_CACHE_DEPTH = INSTR_CACHE_DEPTH_DEF,
    parameter int BURST_LEN_WIDTH   = BURST_LEN_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       INSTR_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0]  INSTR_read_addr,
    output logic [ISA_WIDTH-1:0]       INSTR_to_cache,
    output logic [BURST_LEN_WIDTH-1:0] rd_cnt_instr,
    input  logic                       DATA_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0]  DATA_read_addr,
    input  logic                       DATA_store_req,
    input  logic [DDR_ADDR_WIDTH-1:0]  DATA_write_addr,
    input  logic [DATA_WIDTH-1:0]      DATA_to_ddr,
    output logic [DATA_WIDTH-1:0]      DATA_to_cache,
    output logic [BURST_LEN_WIDTH-1:0] rd_cnt_data,
    output logic                       rd_burst_data_valid,
    output logic                       wr_burst_data_req,
    output logic [3:0]                 state_interface_module,
    ddr_burst_arbiter_if.master        ddr
);

    arb_state_e                 state_d, state_q;
    grant_e                     grant_d, grant_q;
    logic                       rd_burst_req_d, rd_burst_req_q;
    logic [BURST_LEN_WIDTH-1:0] rd_burst_len_d, rd_burst_len_q;
    logic [DDR_ADDR_WIDTH-1:0]  rd_burst_addr_d, rd_burst_addr_q;
    logic                       wr_burst_req_d, wr_burst_req_q;
    logic [BURST_LEN_WIDTH-1:0] wr_burst_len_d, wr_burst_len_q;
    logic [DDR_ADDR_WIDTH-1:0]  wr_burst_addr_d, wr_burst_addr_q;

    logic cnt_instr_load;
    logic cnt_data_load;
    logic cnt_clr;
    logic granted_req;
    logic in_read_instr;
    logic in_read_data;
    logic in_write;

    assign in_read_instr = (state_q == MEM_READ_INSTR);
    assign in_read_data  = (state_q == MEM_READ_DATA);
    assign in_write      = (state_q == MEM_WRITE_DATA_STORE);

    always_comb begin
        case (grant_q)
            GNT_INSTR:   granted_req = INSTR_read_req;
            GNT_DATA_RD: granted_req = DATA_read_req;
            GNT_DATA_ST: granted_req = DATA_store_req;
            default:     granted_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rd_burst_req_d  = rd_burst_req_q;
        rd_burst_len_d  = rd_burst_len_q;
        rd_burst_addr_d = rd_burst_addr_q;
        wr_burst_req_d  = wr_burst_req_q;
        wr_burst_len_d  = wr_burst_len_q;
        wr_burst_addr_d = wr_burst_addr_q;
        cnt_instr_load  = 1'b0;
        cnt_data_load   = 1'b0;
        cnt_clr         = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = pick_grant(DATA_store_req, DATA_read_req, INSTR_read_req);
                case (grant_d)
                    GNT_DATA_ST: begin
                        state_d         = MEM_WRITE_DATA_STORE;
                        wr_burst_req_d  = 1'b1;
                        wr_burst_len_d  = BURST_LEN_WIDTH'(DATA_CACHE_DEPTH);
                        wr_burst_addr_d = DATA_write_addr;
                    end
                    GNT_DATA_RD: begin
                        state_d         = MEM_READ_DATA;
                        rd_burst_req_d  = 1'b1;
                        rd_burst_len_d  = BURST_LEN_WIDTH'(DATA_CACHE_DEPTH);
                        rd_burst_addr_d = DATA_read_addr;
                        cnt_data_load   = 1'b1;
                    end
                    GNT_INSTR: begin
                        state_d         = MEM_READ_INSTR;
                        rd_burst_req_d  = 1'b1;
                        rd_burst_len_d  = BURST_LEN_WIDTH'(INSTR_CACHE_DEPTH);
                        rd_burst_addr_d = INSTR_read_addr;
                        cnt_instr_load  = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM_READ_INSTR, MEM_READ_DATA: begin
                // The controller has accepted the request once beats flow.
                if (ddr.rd_burst_data_valid_ddr || ddr.rd_burst_finish) begin
                    rd_burst_req_d = 1'b0;
                end
                if (ddr.rd_burst_finish) begin
                    state_d = WAIT_RELEASE;
                end
            end
            MEM_WRITE_DATA_STORE: begin
                if (ddr.wr_burst_data_req_ddr || ddr.wr_burst_finish) begin
                    wr_burst_req_d = 1'b0;
                end
                if (ddr.wr_burst_finish) begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // Going through IDLE for one cycle keeps a still-high request
                // from the same cache from being re-granted by accident.
                if (!granted_req) begin
                    cnt_clr = 1'b1;
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            grant_q         <= GNT_NONE;
            rd_burst_req_q  <= 1'b0;
            rd_burst_len_q  <= '0;
            rd_burst_addr_q <= '0;
            wr_burst_req_q  <= 1'b0;
            wr_burst_len_q  <= '0;
            wr_burst_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rd_burst_req_q  <= rd_burst_req_d;
            rd_burst_len_q  <= rd_burst_len_d;
            rd_burst_addr_q <= rd_burst_addr_d;
            wr_burst_req_q  <= wr_burst_req_d;
            wr_burst_len_q  <= wr_burst_len_d;
            wr_burst_addr_q <= wr_burst_addr_d;
        end
    end

    burst_beat_counter #(.WIDTH(BURST_LEN_WIDTH)) u_cnt_instr (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_instr_load),
        .inc  (in_read_instr && ddr.rd_burst_data_valid_ddr),
        .clr  (cnt_clr),
        .cnt  (rd_cnt_instr)
    );

    burst_beat_counter #(.WIDTH(BURST_LEN_WIDTH)) u_cnt_data (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_data_load),
        .inc  (in_read_data && ddr.rd_burst_data_valid_ddr),
        .clr  (cnt_clr),
        .cnt  (rd_cnt_data)
    );

    // Beat paths are combinational so the caches see beats in the same cycle
    // the controller presents them; only the granted side gets non-zero data.
    assign rd_burst_data_valid = (in_read_instr || in_read_data) && ddr.rd_burst_data_valid_ddr;
    assign INSTR_to_cache      = in_read_instr ? ddr.rd_burst_data[ISA_WIDTH-1:0] : '0;
    assign DATA_to_cache       = in_read_data ? ddr.rd_burst_data : '0;
    assign wr_burst_data_req   = in_write && ddr.wr_burst_data_req_ddr;
    assign ddr.wr_burst_data   = in_write ? DATA_to_ddr : '0;

    assign ddr.rd_burst_req    = rd_burst_req_q;
    assign ddr.rd_burst_len    = rd_burst_len_q;
    assign ddr.rd_burst_addr   = rd_burst_addr_q;
    assign ddr.wr_burst_req    = wr_burst_req_q;
    assign ddr.wr_burst_len    = wr_burst_len_q;
    assign ddr.wr_burst_addr   = wr_burst_addr_q;

    assign state_interface_module = state_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
module tb_ddr_burst_arbiter;

    localparam int DW      = 16;
    localparam int IW      = 16;
    localparam int AW      = 28;
    localparam int DDEP    = 16;
    localparam int IDEP    = 16;
    localparam int LW      = 10;
    localparam int CNT_MAX = (1 << LW) - 1;
    localparam int K_INSTR = 0;
    localparam int K_DRD   = 1;
    localparam int K_DST   = 2;

    logic          clk;
    logic          rst;
    logic          INSTR_read_req;
    logic [AW-1:0] INSTR_read_addr;
    logic [IW-1:0] INSTR_to_cache;
    logic [LW-1:0] rd_cnt_instr;
    logic          DATA_read_req;
    logic [AW-1:0] DATA_read_addr;
    logic          DATA_store_req;
    logic [AW-1:0] DATA_write_addr;
    logic [DW-1:0] DATA_to_ddr;
    logic [DW-1:0] DATA_to_cache;
    logic [LW-1:0] rd_cnt_data;
    logic          rd_burst_data_valid;
    logic          wr_burst_data_req;
    logic [3:0]    state_interface_module;

    int checks;
    int failures;

    ddr_burst_arbiter_if bus ();

    ddr_burst_arbiter dut (
        .clk                    (clk),
        .rst                    (rst),
        .INSTR_read_req         (INSTR_read_req),
        .INSTR_read_addr        (INSTR_read_addr),
        .INSTR_to_cache         (INSTR_to_cache),
        .rd_cnt_instr           (rd_cnt_instr),
        .DATA_read_req          (DATA_read_req),
        .DATA_read_addr         (DATA_read_addr),
        .DATA_store_req         (DATA_store_req),
        .DATA_write_addr        (DATA_write_addr),
        .DATA_to_ddr            (DATA_to_ddr),
        .DATA_to_cache          (DATA_to_cache),
        .rd_cnt_data            (rd_cnt_data),
        .rd_burst_data_valid    (rd_burst_data_valid),
        .wr_burst_data_req      (wr_burst_data_req),
        .state_interface_module (state_interface_module),
        .ddr                    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: arbitration priority, state code per grant, and the
    // counter value after a number of beats, straight from the rules.
    function automatic int pick(input logic st, input logic dr, input logic ir);
        if (st) return K_DST;
        if (dr) return K_DRD;
        if (ir) return K_INSTR;
        return -1;
    endfunction

    function automatic logic [3:0] code_of(input int kind);
        if (kind == K_INSTR) return 4'd2;
        if (kind == K_DRD)   return 4'd5;
        return 4'd9;
    endfunction

    function automatic int cnt_after(input int beats);
        int v;
        v = 2 + beats;
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic set_req(input int kind, input logic val);
        if (kind == K_INSTR)    INSTR_read_req = val;
        else if (kind == K_DRD) DATA_read_req  = val;
        else                    DATA_store_req = val;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, state_interface_module, 4'd0);
        chk({tag, "_cnt_i"}, rd_cnt_instr, 0);
        chk({tag, "_cnt_d"}, rd_cnt_data, 0);
        chk({tag, "_rd_req"}, bus.rd_burst_req, 0);
        chk({tag, "_rd_len"}, bus.rd_burst_len, 0);
        chk({tag, "_rd_addr"}, bus.rd_burst_addr, 0);
        chk({tag, "_wr_req"}, bus.wr_burst_req, 0);
        chk({tag, "_wr_len"}, bus.wr_burst_len, 0);
        chk({tag, "_wr_addr"}, bus.wr_burst_addr, 0);
        chk({tag, "_i_cache"}, INSTR_to_cache, 0);
        chk({tag, "_d_cache"}, DATA_to_cache, 0);
        chk({tag, "_rd_valid"}, rd_burst_data_valid, 0);
        chk({tag, "_wr_dreq"}, wr_burst_data_req, 0);
    endtask

    // Plays the DDR controller for one burst of the expected kind, from grant
    // through finish, WAIT_RELEASE and the requester dropping its request.
    task automatic run_burst(input int kind, input int nbeats, input bit seq_data);
        bit            got;
        int            k;
        int            sent;
        bit            gap;
        bit            issue;
        bit            pend;
        int            hold;
        logic [DW-1:0] beat;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] own_cnt;
        logic [LW-1:0] oth_cnt;
        logic [DW-1:0] own_data;
        logic [DW-1:0] oth_data;
        int            fin_cnt;

        exp_addr = (kind == K_DST) ? DATA_write_addr :
                   (kind == K_DRD) ? DATA_read_addr : INSTR_read_addr;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            #1;
            got = bus.rd_burst_req || bus.wr_burst_req;
        end
        if (!got) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        chk("grant_state", state_interface_module, code_of(kind));

        if (kind == K_DST) begin
            chk("wr_len", bus.wr_burst_len, DDEP);
            chk("wr_addr", bus.wr_burst_addr, exp_addr);
            chk("wr_no_rd_req", bus.rd_burst_req, 0);
            sent = 0;
            pend = 0;
            while (sent < nbeats || pend) begin
                issue = (sent < nbeats) && ($urandom_range(0, 3) != 0);
                bus.wr_burst_data_req_ddr = issue;
                beat = DW'($urandom);
                DATA_to_ddr = beat;
                #1;
                chk("wr_req_hold", bus.wr_burst_req, sent == 0);
                chk("wr_dreq_fwd", wr_burst_data_req, issue);
                if (pend) chk("wr_data_fwd", bus.wr_burst_data, beat);
                chk("wr_cnt_d", rd_cnt_data, 0);
                pend = issue;
                if (issue) sent++;
                tick();
            end
            bus.wr_burst_data_req_ddr = 1'b0;
            fin_cnt = 0;
        end else begin
            chk("rd_len", bus.rd_burst_len, (kind == K_DRD) ? DDEP : IDEP);
            chk("rd_addr", bus.rd_burst_addr, exp_addr);
            chk("rd_no_wr_req", bus.wr_burst_req, 0);
            k = 0;
            while (k < nbeats) begin
                gap = ($urandom_range(0, 3) == 0);
                beat = seq_data ? DW'(16'hA000 + k) : DW'($urandom);
                bus.rd_burst_data_valid_ddr = !gap;
                bus.rd_burst_data = beat;
                #1;
                own_cnt  = (kind == K_DRD) ? rd_cnt_data : rd_cnt_instr;
                oth_cnt  = (kind == K_DRD) ? rd_cnt_instr : rd_cnt_data;
                own_data = (kind == K_DRD) ? DATA_to_cache : INSTR_to_cache;
                oth_data = (kind == K_DRD) ? INSTR_to_cache : DATA_to_cache;
                chk("rd_req_hold", bus.rd_burst_req, k == 0);
                chk("rd_valid_fwd", rd_burst_data_valid, !gap);
                if (!gap) begin
                    chk("rd_cnt_own", own_cnt, cnt_after(k));
                    chk("rd_data_own", own_data, beat);
                    chk("rd_data_other", oth_data, 0);
                    chk("rd_cnt_other", oth_cnt, 0);
                    k++;
                end
                tick();
            end
            bus.rd_burst_data_valid_ddr = 1'b0;
            fin_cnt = cnt_after(nbeats);
        end

        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            #1;
            chk("burst_state_hold", state_interface_module, code_of(kind));
            tick();
        end
        if (kind == K_DST) bus.wr_burst_finish = 1'b1;
        else               bus.rd_burst_finish = 1'b1;
        #1;
        chk("finish_cycle_state", state_interface_module, code_of(kind));
        tick();
        bus.wr_burst_finish = 1'b0;
        bus.rd_burst_finish = 1'b0;

        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            #1;
            chk("wait_state", state_interface_module, 4'd12);
            chk("wait_cnt_hold", (kind == K_INSTR) ? rd_cnt_instr : rd_cnt_data,
                (kind == K_INSTR) ? fin_cnt : ((kind == K_DRD) ? fin_cnt : 0));
            tick();
        end
        set_req(kind, 1'b0);
        #1;
        chk("drop_cycle_state", state_interface_module, 4'd12);
        tick();
        #1;
        chk("release_state", state_interface_module, 4'd0);
        chk("release_cnt_i", rd_cnt_instr, 0);
        chk("release_cnt_d", rd_cnt_data, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        INSTR_read_req  = 1'b0;
        INSTR_read_addr = '0;
        DATA_read_req   = 1'b0;
        DATA_read_addr  = '0;
        DATA_store_req  = 1'b0;
        DATA_write_addr = '0;
        DATA_to_ddr     = '0;
        bus.rd_burst_data           = '0;
        bus.rd_burst_data_valid_ddr = 1'b0;
        bus.rd_burst_finish         = 1'b0;
        bus.wr_burst_data_req_ddr   = 1'b0;
        bus.wr_burst_finish         = 1'b0;
        #2;
        chk_quiet("reset");
        #10;
        rst = 1'b1;

        // Data line fill with sequential beat data.
        DATA_read_addr = 28'h0028000;
        DATA_read_req  = 1'b1;
        run_burst(K_DRD, DDEP, 1'b1);

        // Instruction line fill.
        INSTR_read_addr = AW'($urandom);
        INSTR_read_req  = 1'b1;
        run_burst(K_INSTR, IDEP, 1'b0);

        // Data line write-back.
        DATA_write_addr = 28'h0028000;
        DATA_store_req  = 1'b1;
        run_burst(K_DST, DDEP, 1'b0);

        // All three requests in the same cycle, then random request mixes.
        for (int r = 0; r < 5; r++) begin
            int mix;
            int kind;
            mix = (r == 0) ? 7 : $urandom_range(1, 7);
            INSTR_read_addr = AW'($urandom);
            DATA_read_addr  = AW'($urandom);
            DATA_write_addr = AW'($urandom);
            INSTR_read_req  = mix[0];
            DATA_read_req   = mix[1];
            DATA_store_req  = mix[2];
            kind = pick(DATA_store_req, DATA_read_req, INSTR_read_req);
            for (int g = 0; g < 3 && kind >= 0; g++) begin
                run_burst(kind, (kind == K_INSTR) ? IDEP : DDEP, 1'b0);
                kind = pick(DATA_store_req, DATA_read_req, INSTR_read_req);
            end
            chk("contention_drained", pick(DATA_store_req, DATA_read_req, INSTR_read_req), -1);
        end

        // Stray finish pulses while idle.
        bus.rd_burst_finish = 1'b1;
        bus.wr_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        bus.wr_burst_finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stray_finish_state", state_interface_module, 4'd0);
            chk("stray_finish_rd_req", bus.rd_burst_req, 0);
            tick();
        end

        // Reset in the middle of a data fill, at beat 7.
        DATA_read_addr = AW'($urandom);
        DATA_read_req  = 1'b1;
        tick();
        #1;
        chk("mid_rst_grant", state_interface_module, 4'd5);
        tick();
        for (int k = 0; k < 7; k++) begin
            bus.rd_burst_data_valid_ddr = 1'b1;
            bus.rd_burst_data = DW'($urandom);
            tick();
        end
        bus.rd_burst_data_valid_ddr = 1'b1;
        #1;
        chk("mid_rst_cnt_pre", rd_cnt_data, cnt_after(7));
        rst = 1'b0;
        #1;
        chk_quiet("mid_rst");
        tick();
        bus.rd_burst_data_valid_ddr = 1'b0;
        rst = 1'b1;
        run_burst(K_DRD, DDEP, 1'b0);

        // Long burst to push the data counter into saturation.
        DATA_read_addr = AW'($urandom);
        DATA_read_req  = 1'b1;
        run_burst(K_DRD, CNT_MAX + 8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
